uart_axil_ctrl: RTL and testbench

- AXI4-Lite slave register controller that sequences the UART core (baud generator, RX/TX units, RX/TX FIFOs).
- Converts bus writes into single-cycle TX FIFO pushes and bus reads into single-cycle RX FIFO pops.
- Drives the runtime baud limit and reports FIFO status.
- Sits between the system interconnect and the UART core; one outstanding transaction at a time.

---
 rtl/uart_axil_ctrl_if.sv | 36 +++
 rtl/uart_axil_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_uart_axil_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_axil_ctrl_if.sv
// AXI4-Lite bus bundle between the interconnect (master) and uart_axil_ctrl (slave).
interface uart_axil_ctrl_if #(
   parameter int ADDR_WIDTH = 4
);
   logic [ADDR_WIDTH-1:0] s_axi_awaddr;
   logic                  s_axi_awvalid;
   logic                  s_axi_awready;
   logic [31:0]           s_axi_wdata;
   logic [3:0]            s_axi_wstrb;
   logic                  s_axi_wvalid;
   logic                  s_axi_wready;
   logic [1:0]            s_axi_bresp;
   logic                  s_axi_bvalid;
   logic                  s_axi_bready;
   logic [ADDR_WIDTH-1:0] s_axi_araddr;
   logic                  s_axi_arvalid;
   logic                  s_axi_arready;
   logic [31:0]           s_axi_rdata;
   logic [1:0]            s_axi_rresp;
   logic                  s_axi_rvalid;
   logic                  s_axi_rready;

   modport slave (
      input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
             s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
      output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
             s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
   );

   modport master (
      output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
             s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
      input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
             s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
   );
endinterface

// File: rtl/uart_axil_ctrl.sv
// AXI4-Lite register front end for the UART core: TX push, RX pop, status and baud limit.
// Define UART_AXIL_CTRL_IRQ_EN to add the STATUS interrupt enables and the irq output.
module uart_axil_ctrl #(
   parameter int DBITS        = 8,
   parameter int BAUD_DEFAULT = 651,
   parameter int ADDR_WIDTH   = 4
) (
   input  logic             clk_100MHz,
   input  logic             reset,
   uart_axil_ctrl_if.slave  s_axi,
   output logic             uart_write,
   output logic [DBITS-1:0] uart_write_data,
   input  logic             uart_tx_full,
   output logic             uart_read,
   input  logic [DBITS-1:0] uart_read_data,
   input  logic             uart_rx_empty,
   input  logic             uart_rx_full,
   output logic [15:0]      br_limit
`ifdef UART_AXIL_CTRL_IRQ_EN
   ,
   output logic             irq
`endif
);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {ST_IDLE, ST_WEXEC, ST_WRESP, ST_REXEC, ST_RRESP} state_t;
   typedef enum logic [1:0] {REG_TXDATA, REG_RXDATA, REG_STATUS, REG_BAUD} reg_t;

   state_t      r_state, w_state_next;
   logic        r_aw_held, r_w_held;
   reg_t        r_awsel, r_arsel;
   logic [15:0] r_wdata;
   logic [1:0]  r_wstrb;
   logic [1:0]  r_bresp, r_rresp;
   logic [31:0] r_rdata;
   logic [15:0] r_br_limit;

   logic        w_awready, w_wready, w_arready;
   logic        w_aw_hs, w_w_hs, w_ar_hs;
   logic        w_push, w_pop;
   logic [15:0] w_baud_new;
   logic        w_baud_we;
   logic [1:0]  w_bresp;
   logic [31:0] w_rdata_sel;
   logic [1:0]  w_ie;
   logic        w_unused;

   always_ff @(posedge clk_100MHz) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_next;
   end

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_next = r_state;
      w_awready    = 1'b0;
      w_wready     = 1'b0;
      w_arready    = 1'b0;
      w_aw_hs      = 1'b0;
      w_w_hs       = 1'b0;
      w_ar_hs      = 1'b0;
      w_push       = 1'b0;
      w_pop        = 1'b0;
      if (!reset) begin
         case (r_state)
            ST_IDLE: begin
               w_awready = ~r_aw_held;
               w_wready  = ~r_w_held;
               w_arready = ~r_aw_held & ~r_w_held & ~s_axi.s_axi_awvalid;
               w_aw_hs   = w_awready & s_axi.s_axi_awvalid;
               w_w_hs    = w_wready & s_axi.s_axi_wvalid;
               w_ar_hs   = w_arready & s_axi.s_axi_arvalid;
               if ((r_aw_held | w_aw_hs) & (r_w_held | w_w_hs)) w_state_next = ST_WEXEC;
               else if (w_ar_hs)                                 w_state_next = ST_REXEC;
            end
            ST_WEXEC: begin
               w_push       = (r_awsel == REG_TXDATA) & r_wstrb[0] & ~uart_tx_full;
               w_state_next = ST_WRESP;
            end
            ST_WRESP: if (s_axi.s_axi_bready) w_state_next = ST_IDLE;
            ST_REXEC: begin
               w_pop        = (r_arsel == REG_RXDATA) & ~uart_rx_empty;
               w_state_next = ST_RRESP;
            end
            ST_RRESP: if (s_axi.s_axi_rready) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
         endcase
      end
   end

   // A baud write that would leave the limit at zero is refused; it would stall the generator.
   always_comb begin
      w_baud_new = {r_wstrb[1] ? r_wdata[15:8] : r_br_limit[15:8],
                    r_wstrb[0] ? r_wdata[7:0]  : r_br_limit[7:0]};
      w_baud_we  = 1'b0;
      w_bresp    = RESP_OKAY;
      case (r_awsel)
         REG_TXDATA: if (r_wstrb[0] && uart_tx_full) w_bresp = RESP_SLVERR;
         REG_BAUD: begin
            if (w_baud_new == 16'd0) w_bresp   = RESP_SLVERR;
            else                     w_baud_we = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      w_rdata_sel = '0;
      case (r_arsel)
         REG_RXDATA: if (!uart_rx_empty) w_rdata_sel = 32'({1'b1, uart_read_data});
         REG_STATUS: w_rdata_sel = {27'd0, w_ie, uart_tx_full, uart_rx_full, uart_rx_empty};
         REG_BAUD:   w_rdata_sel = {16'd0, r_br_limit};
         default:    ;
      endcase
   end

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         r_aw_held  <= 1'b0;
         r_w_held   <= 1'b0;
         r_awsel    <= REG_TXDATA;
         r_arsel    <= REG_TXDATA;
         r_wdata    <= '0;
         r_wstrb    <= '0;
         r_bresp    <= RESP_OKAY;
         r_rresp    <= RESP_OKAY;
         r_rdata    <= '0;
         r_br_limit <= 16'(BAUD_DEFAULT);
      end else begin
         if (w_aw_hs) begin
            r_aw_held <= 1'b1;
            r_awsel   <= reg_t'(s_axi.s_axi_awaddr[3:2]);
         end
         if (w_w_hs) begin
            r_w_held <= 1'b1;
            r_wdata  <= s_axi.s_axi_wdata[15:0];
            r_wstrb  <= s_axi.s_axi_wstrb[1:0];
         end
         if (w_ar_hs) r_arsel <= reg_t'(s_axi.s_axi_araddr[3:2]);
         if (r_state == ST_WEXEC) begin
            r_bresp <= w_bresp;
            if (w_baud_we) r_br_limit <= w_baud_new;
         end
         if (r_state == ST_WRESP && s_axi.s_axi_bready) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
         end
         if (r_state == ST_REXEC) begin
            r_rdata <= w_rdata_sel;
            r_rresp <= RESP_OKAY;
         end
      end
   end

`ifdef UART_AXIL_CTRL_IRQ_EN
   logic [1:0] r_ie;
   logic       r_irq;

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         r_ie  <= 2'b00;
         r_irq <= 1'b0;
      end else begin
         if (r_state == ST_WEXEC && r_awsel == REG_STATUS && r_wstrb[0]) r_ie <= r_wdata[4:3];
         r_irq <= (r_ie[0] & ~uart_rx_empty) | (r_ie[1] & ~uart_tx_full);
      end
   end

   assign w_ie = r_ie;
   assign irq  = r_irq;
`else
   assign w_ie = 2'b00;
`endif

   assign s_axi.s_axi_awready = w_awready;
   assign s_axi.s_axi_wready  = w_wready;
   assign s_axi.s_axi_arready = w_arready;
   assign s_axi.s_axi_bvalid  = (r_state == ST_WRESP) & ~reset;
   assign s_axi.s_axi_bresp   = r_bresp;
   assign s_axi.s_axi_rvalid  = (r_state == ST_RRESP) & ~reset;
   assign s_axi.s_axi_rresp   = r_rresp;
   assign s_axi.s_axi_rdata   = r_rdata;

   assign uart_write      = w_push;
   assign uart_read       = w_pop;
   assign uart_write_data = r_wdata[DBITS-1:0];
   assign br_limit        = r_br_limit;

   assign w_unused = ^{s_axi.s_axi_awaddr, s_axi.s_axi_araddr, s_axi.s_axi_wdata, s_axi.s_axi_wstrb};

endmodule

// File: tb/tb_uart_axil_ctrl.sv
// Directed scoreboard bench for uart_axil_ctrl: bus transactions, UART pulses, baud updates, reset abort.
module tb_uart_axil_ctrl;
   localparam int DBITS        = 8;
   localparam int BAUD_DEFAULT = 651;
   localparam int ADDR_WIDTH   = 4;
   localparam logic [3:0] A_TX = 4'h0, A_RX = 4'h4, A_ST = 4'h8, A_BAUD = 4'hC;

   logic             clk_100MHz = 1'b0;
   logic             reset      = 1'b1;
   logic             uart_write, uart_read;
   logic [DBITS-1:0] uart_write_data;
   logic             uart_tx_full  = 1'b0;
   logic [DBITS-1:0] uart_read_data = '0;
   logic             uart_rx_empty = 1'b1;
   logic             uart_rx_full  = 1'b0;
   logic [15:0]      br_limit;
`ifdef UART_AXIL_CTRL_IRQ_EN
   logic             irq;
`endif

   uart_axil_ctrl_if #(.ADDR_WIDTH(ADDR_WIDTH)) axi ();

   uart_axil_ctrl #(.DBITS(DBITS), .BAUD_DEFAULT(BAUD_DEFAULT), .ADDR_WIDTH(ADDR_WIDTH)) dut (
      .clk_100MHz     (clk_100MHz),
      .reset          (reset),
      .s_axi          (axi),
      .uart_write     (uart_write),
      .uart_write_data(uart_write_data),
      .uart_tx_full   (uart_tx_full),
      .uart_read      (uart_read),
      .uart_read_data (uart_read_data),
      .uart_rx_empty  (uart_rx_empty),
      .uart_rx_full   (uart_rx_full),
      .br_limit       (br_limit)
`ifdef UART_AXIL_CTRL_IRQ_EN
      ,
      .irq            (irq)
`endif
   );

   always #5 clk_100MHz = ~clk_100MHz;

   int          n_vec  = 0;
   int          n_miss = 0;
   logic [1:0]  exp_b_q[$];
   logic [31:0] exp_r_q[$];
   logic [7:0]  exp_wr_q[$];
   logic [7:0]  act_wr_q[$];
   int          exp_rd_cnt = 0;
   int          act_rd_cnt = 0;
   int          both_cnt   = 0;
   logic [15:0] m_baud = 16'(BAUD_DEFAULT);
   logic [1:0]  m_ie   = 2'b00;
   time         t_bdone, t_ardone;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_miss++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   always @(negedge clk_100MHz) begin
      if (uart_write) act_wr_q.push_back(uart_write_data);
      if (uart_read) act_rd_cnt++;
      if (uart_write && uart_read) both_cnt++;
   end

   task automatic model_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
      logic [15:0] nb;
      case (addr[3:2])
         2'd0: begin
            if (!strb[0])          exp_b_q.push_back(2'b00);
            else if (uart_tx_full) exp_b_q.push_back(2'b10);
            else begin
               exp_b_q.push_back(2'b00);
               exp_wr_q.push_back(data[7:0]);
            end
         end
         2'd3: begin
            nb = m_baud;
            if (strb[0]) nb[7:0]  = data[7:0];
            if (strb[1]) nb[15:8] = data[15:8];
            if (nb == 16'd0) exp_b_q.push_back(2'b10);
            else begin
               m_baud = nb;
               exp_b_q.push_back(2'b00);
            end
         end
         2'd2: begin
`ifdef UART_AXIL_CTRL_IRQ_EN
            if (strb[0]) m_ie = data[4:3];
`endif
            exp_b_q.push_back(2'b00);
         end
         default: exp_b_q.push_back(2'b00);
      endcase
   endtask

   task automatic model_read(input logic [3:0] addr, output logic [31:0] value);
      case (addr[3:2])
         2'd1: begin
            value = uart_rx_empty ? 32'd0 : {23'd0, 1'b1, uart_read_data};
            if (!uart_rx_empty) exp_rd_cnt++;
         end
         2'd2:    value = {27'd0, m_ie, uart_tx_full, uart_rx_full, uart_rx_empty};
         2'd3:    value = {16'd0, m_baud};
         default: value = 32'd0;
      endcase
   endtask

   task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_delay, input int w_delay, input int b_delay);
      bit aw_done = 0, w_done = 0, aw_hs, w_hs, b_hs;
      int cyc = 0, lat = 0;
      logic [1:0] exp_b;
      model_write(addr, data, strb);
      while (!(aw_done && w_done) && cyc < 40) begin
         if (!aw_done && cyc >= aw_delay) begin
            axi.s_axi_awaddr  = addr;
            axi.s_axi_awvalid = 1'b1;
         end
         if (!w_done && cyc >= w_delay) begin
            axi.s_axi_wdata  = data;
            axi.s_axi_wstrb  = strb;
            axi.s_axi_wvalid = 1'b1;
         end
         @(negedge clk_100MHz);
         aw_hs = axi.s_axi_awvalid && axi.s_axi_awready;
         w_hs  = axi.s_axi_wvalid && axi.s_axi_wready;
         @(posedge clk_100MHz); #1;
         if (aw_hs) begin aw_done = 1; axi.s_axi_awvalid = 1'b0; end
         if (w_hs)  begin w_done  = 1; axi.s_axi_wvalid  = 1'b0; end
         cyc++;
      end
      axi.s_axi_awvalid = 1'b0;
      axi.s_axi_wvalid  = 1'b0;
      check("aw_w_accepted", 32'({aw_done, w_done}), 32'd3);
      do begin @(negedge clk_100MHz); lat++; end while (!axi.s_axi_bvalid && lat < 20);
      check("b_latency", lat, 2);
      exp_b = exp_b_q.pop_front();
      check("bresp", 32'(axi.s_axi_bresp), 32'(exp_b));
      repeat (b_delay) begin
         @(posedge clk_100MHz); @(negedge clk_100MHz);
         check("bvalid_hold", 32'(axi.s_axi_bvalid), 1);
         check("bresp_hold", 32'(axi.s_axi_bresp), 32'(exp_b));
      end
      @(posedge clk_100MHz); #1;
      axi.s_axi_bready = 1'b1;
      @(negedge clk_100MHz);
      b_hs    = axi.s_axi_bvalid;
      t_bdone = $time;
      @(posedge clk_100MHz); #1;
      axi.s_axi_bready = 1'b0;
      check("b_handshake", 32'(b_hs), 1);
      check("wr_pulse_count", act_wr_q.size(), exp_wr_q.size());
      while (exp_wr_q.size() > 0 && act_wr_q.size() > 0)
         check("wr_pulse_data", 32'(act_wr_q.pop_front()), 32'(exp_wr_q.pop_front()));
   endtask

   task automatic axi_read(input logic [3:0] addr, input int r_delay, input bit do_reset);
      bit ar_done = 0, ar_hs, r_hs;
      int cyc = 0, lat = 0;
      logic [31:0] exp_d;
      axi.s_axi_araddr  = addr;
      axi.s_axi_arvalid = 1'b1;
      while (!ar_done && cyc < 60) begin
         @(negedge clk_100MHz);
         ar_hs = axi.s_axi_arvalid && axi.s_axi_arready;
         @(posedge clk_100MHz); #1;
         if (ar_hs) begin
            ar_done  = 1;
            t_ardone = $time;
            axi.s_axi_arvalid = 1'b0;
            model_read(addr, exp_d);
            exp_r_q.push_back(exp_d);
         end
         cyc++;
      end
      axi.s_axi_arvalid = 1'b0;
      check("ar_accepted", 32'(ar_done), 1);
      if (ar_done) begin
         do begin @(negedge clk_100MHz); lat++; end while (!axi.s_axi_rvalid && lat < 20);
         check("r_latency", lat, 2);
         exp_d = exp_r_q.pop_front();
         check("rdata", axi.s_axi_rdata, exp_d);
         check("rresp", 32'(axi.s_axi_rresp), 0);
         repeat (r_delay) begin
            @(posedge clk_100MHz); @(negedge clk_100MHz);
            check("rvalid_hold", 32'(axi.s_axi_rvalid), 1);
            check("rdata_hold", axi.s_axi_rdata, exp_d);
         end
         if (do_reset) begin
            @(posedge clk_100MHz); #1;
            reset = 1'b1;
            @(posedge clk_100MHz); #1;
            m_baud = 16'(BAUD_DEFAULT);
            m_ie   = 2'b00;
            check("rvalid_after_reset", 32'(axi.s_axi_rvalid), 0);
            check("br_limit_after_reset", 32'(br_limit), 32'(m_baud));
            check("rdata_after_reset", axi.s_axi_rdata, 0);
            @(posedge clk_100MHz); #1;
            reset = 1'b0;
         end else begin
            @(posedge clk_100MHz); #1;
            axi.s_axi_rready = 1'b1;
            @(negedge clk_100MHz);
            r_hs = axi.s_axi_rvalid;
            @(posedge clk_100MHz); #1;
            axi.s_axi_rready = 1'b0;
            check("r_handshake", 32'(r_hs), 1);
         end
      end
      check("rd_pulse_count", act_rd_cnt, exp_rd_cnt);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "watchdog expired");
   end

   initial begin
      axi.s_axi_awaddr  = '0;
      axi.s_axi_awvalid = 1'b0;
      axi.s_axi_wdata   = '0;
      axi.s_axi_wstrb   = '0;
      axi.s_axi_wvalid  = 1'b0;
      axi.s_axi_bready  = 1'b0;
      axi.s_axi_araddr  = '0;
      axi.s_axi_arvalid = 1'b0;
      axi.s_axi_rready  = 1'b0;

      // Reset state while reset is still held.
      repeat (3) @(posedge clk_100MHz);
      #1;
      check("rst_awready", 32'(axi.s_axi_awready), 0);
      check("rst_wready", 32'(axi.s_axi_wready), 0);
      check("rst_arready", 32'(axi.s_axi_arready), 0);
      check("rst_bvalid", 32'(axi.s_axi_bvalid), 0);
      check("rst_rvalid", 32'(axi.s_axi_rvalid), 0);
      check("rst_bresp", 32'(axi.s_axi_bresp), 0);
      check("rst_rresp", 32'(axi.s_axi_rresp), 0);
      check("rst_rdata", axi.s_axi_rdata, 0);
      check("rst_uart_write", 32'(uart_write), 0);
      check("rst_uart_read", 32'(uart_read), 0);
      check("rst_write_data", 32'(uart_write_data), 0);
      check("rst_br_limit", 32'(br_limit), 32'(m_baud));
      reset = 1'b0;
      @(posedge clk_100MHz); #1;

      axi_read(A_BAUD, 0, 0);
      axi_read(A_ST, 0, 0);

      // TXDATA: AW leads W, W leads AW, same cycle, TX full, byte 0 not strobed.
      axi_write(A_TX, 32'h41, 4'b0001, 0, 2, 1);
      axi_write(A_TX, 32'h5A, 4'b0001, 2, 0, 0);
      axi_write(A_TX, 32'h3C, 4'b1111, 0, 0, 0);
      uart_tx_full = 1'b1;
      axi_write(A_TX, 32'h55, 4'b0001, 0, 0, 2);
      uart_tx_full = 1'b0;
      axi_write(A_TX, 32'h77, 4'b0010, 0, 0, 0);
      axi_read(A_TX, 0, 0);

      // RXDATA pop with a stalled consumer, then an empty-FIFO read.
      uart_read_data = 8'hA5;
      uart_rx_empty  = 1'b0;
      axi_read(A_RX, 3, 0);
      uart_rx_empty  = 1'b1;
      axi_read(A_RX, 0, 0);

      // STATUS with every flag flipped from idle, then a STATUS write.
      uart_tx_full  = 1'b1;
      uart_rx_full  = 1'b1;
      uart_rx_empty = 1'b0;
      axi_read(A_ST, 0, 0);
      uart_tx_full  = 1'b0;
      uart_rx_full  = 1'b0;
      uart_rx_empty = 1'b1;
      axi_write(A_ST, 32'h18, 4'b0001, 0, 0, 0);
      axi_read(A_ST, 0, 0);
      axi_write(A_RX, 32'hFF, 4'b1111, 0, 0, 0);

      // Baud limit updates, zero rejection, partial strobes.
      axi_write(A_BAUD, 32'h0034, 4'b0011, 0, 0, 0);
      check("br_limit_52", 32'(br_limit), 32'(m_baud));
      axi_write(A_BAUD, 32'h0000, 4'b0011, 1, 0, 0);
      check("br_limit_kept", 32'(br_limit), 32'(m_baud));
      axi_write(A_BAUD, 32'h0100, 4'b0011, 0, 0, 0);
      axi_write(A_BAUD, 32'h0000, 4'b0001, 0, 0, 0);
      check("br_limit_256", 32'(br_limit), 32'(m_baud));

      // AW and AR together: the write must complete before the read is accepted.
      fork
         axi_write(A_BAUD, 32'h0034, 4'b0011, 0, 0, 0);
         axi_read(A_BAUD, 0, 0);
      join
      check("ar_after_write", 32'(t_ardone > t_bdone), 1);
      check("br_limit_concurrent", 32'(br_limit), 32'(m_baud));

      // Reset lands while a read response is stalled in RRESP.
      axi_read(A_BAUD, 2, 1);
      repeat (5) @(posedge clk_100MHz);
      #1;
      check("no_wr_after_reset", act_wr_q.size(), 0);
      check("no_rd_after_reset", act_rd_cnt, exp_rd_cnt);
      axi_read(A_BAUD, 0, 0);
      check("never_both_pulses", both_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
